// File: rtl/topo_sort_scheduler.sv
// Kahn-style topological sort sequencer: scans an external indegree list, keeps a
// ready FIFO of zero-degree nodes and walks each popped node's successor stream.
module topo_sort_scheduler #(
    parameter int MAX_NODES  = 1024,
    parameter int NODE_WIDTH = $clog2(MAX_NODES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NODE_WIDTH:0]   node_count,
    output logic [NODE_WIDTH-1:0] node_sel,
    output logic                  decrement_degree,
    input  logic [NODE_WIDTH-1:0] node_degree,
    output logic                  adj_req_valid,
    output logic [NODE_WIDTH-1:0] adj_req_node,
    input  logic                  adj_req_ready,
    input  logic                  adj_rsp_valid,
    input  logic [NODE_WIDTH-1:0] adj_rsp_node,
    input  logic                  adj_rsp_last,
    input  logic                  adj_rsp_empty,
    output logic                  adj_rsp_ready,
    output logic                  order_valid,
    output logic [NODE_WIDTH-1:0] order_node,
    output logic                  busy,
    output logic                  done,
    output logic                  cycle_detected
);

    localparam logic [NODE_WIDTH:0]   DEPTH    = (NODE_WIDTH+1)'(MAX_NODES);
    localparam logic [NODE_WIDTH-1:0] LAST_PTR = NODE_WIDTH'(MAX_NODES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        POP,
        ADJ_REQ,
        ADJ_RSP,
        DECR_WAIT,
        FINISH
    } state_t;

    state_t state, state_next;

    logic [NODE_WIDTH:0]   n_reg;
    logic [NODE_WIDTH:0]   scan_idx;
    logic [NODE_WIDTH:0]   emitted;
    logic [NODE_WIDTH-1:0] cur_node;
    logic [NODE_WIDTH-1:0] lat_node;
    logic                  lat_last;
    logic                  cycle_flag;

    logic [NODE_WIDTH-1:0] fifo_mem [MAX_NODES];
    logic [NODE_WIDTH-1:0] rd_ptr;
    logic [NODE_WIDTH-1:0] wr_ptr;
    logic [NODE_WIDTH:0]   fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [NODE_WIDTH-1:0] head;

    logic                  push_req;
    logic                  push_ok;
    logic [NODE_WIDTH-1:0] push_data;
    logic                  pop_req;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DEPTH);
    assign head       = fifo_mem[rd_ptr];
    assign push_ok    = push_req && !fifo_full && !rst;

    // Next-state, FIFO push/pop requests and all externally visible outputs.
    always_comb begin
        state_next       = state;
        push_req         = 1'b0;
        push_data        = '0;
        pop_req          = 1'b0;
        node_sel         = '0;
        decrement_degree = 1'b0;
        adj_req_valid    = 1'b0;
        adj_req_node     = '0;
        adj_rsp_ready    = 1'b0;
        order_valid      = 1'b0;
        order_node       = '0;
        busy             = 1'b0;
        done             = 1'b0;
        cycle_detected   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (node_count == '0) ? FINISH : SCAN;
                end
            end
            SCAN: begin
                // Degree arriving now belongs to the node issued last cycle.
                if (scan_idx != '0 && node_degree == '0) begin
                    push_req  = 1'b1;
                    push_data = NODE_WIDTH'(scan_idx - 1'b1);
                end
                if (scan_idx == n_reg) begin
                    state_next = POP;
                end
            end
            POP: begin
                if (!fifo_empty) begin
                    pop_req    = 1'b1;
                    state_next = ADJ_REQ;
                end else begin
                    state_next = FINISH;
                end
            end
            ADJ_REQ: begin
                if (adj_req_ready) begin
                    state_next = ADJ_RSP;
                end
            end
            ADJ_RSP: begin
                if (adj_rsp_valid) begin
                    state_next = adj_rsp_empty ? POP : DECR_WAIT;
                end
            end
            DECR_WAIT: begin
                if (node_degree == '0) begin
                    push_req  = 1'b1;
                    push_data = lat_node;
                end
                state_next = lat_last ? POP : ADJ_RSP;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!rst) begin
            busy           = (state != IDLE);
            cycle_detected = cycle_flag || (state == FINISH && emitted != n_reg);
            case (state)
                SCAN: begin
                    if (scan_idx < n_reg) begin
                        node_sel = scan_idx[NODE_WIDTH-1:0];
                    end
                end
                POP: begin
                    if (!fifo_empty) begin
                        order_valid = 1'b1;
                        order_node  = head;
                    end
                end
                ADJ_REQ: begin
                    adj_req_valid = 1'b1;
                    adj_req_node  = cur_node;
                end
                ADJ_RSP: begin
                    adj_rsp_ready = 1'b1;
                    if (adj_rsp_valid && !adj_rsp_empty) begin
                        node_sel         = adj_rsp_node;
                        decrement_degree = 1'b1;
                    end
                end
                FINISH: begin
                    done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // State register plus counters, latches and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n_reg      <= '0;
            scan_idx   <= '0;
            emitted    <= '0;
            cur_node   <= '0;
            lat_node   <= '0;
            lat_last   <= 1'b0;
            cycle_flag <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg      <= node_count;
                        scan_idx   <= '0;
                        emitted    <= '0;
                        cycle_flag <= 1'b0;
                        rd_ptr     <= '0;
                        wr_ptr     <= '0;
                        fifo_count <= '0;
                    end
                end
                SCAN: begin
                    if (scan_idx < n_reg) begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                POP: begin
                    if (!fifo_empty) begin
                        cur_node <= head;
                        emitted  <= emitted + 1'b1;
                    end
                end
                ADJ_RSP: begin
                    if (adj_rsp_valid && !adj_rsp_empty) begin
                        lat_node <= adj_rsp_node;
                        lat_last <= adj_rsp_last;
                    end
                end
                FINISH: begin
                    if (emitted != n_reg) begin
                        cycle_flag <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Pushes and pops live in disjoint states, so at most one fires per cycle.
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_req) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push_ok && !pop_req) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop_req && !push_ok) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (push_req && fifo_full) begin
                cycle_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_topo_sort_scheduler.sv
// Bench for topo_sort_scheduler: models the indegree RAM and the adjacency source,
// and compares the emitted order against per-scenario expected sequences.
module tb_topo_sort_scheduler;

    localparam int MAXN = 16;
    localparam int NW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NW:0]   node_count;
    logic [NW-1:0] node_sel;
    logic          decrement_degree;
    logic [NW-1:0] node_degree;
    logic          adj_req_valid;
    logic [NW-1:0] adj_req_node;
    logic          adj_req_ready;
    logic          adj_rsp_valid;
    logic [NW-1:0] adj_rsp_node;
    logic          adj_rsp_last;
    logic          adj_rsp_empty;
    logic          adj_rsp_ready;
    logic          order_valid;
    logic [NW-1:0] order_node;
    logic          busy;
    logic          done;
    logic          cycle_detected;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    topo_sort_scheduler #(.MAX_NODES(MAXN), .NODE_WIDTH(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .node_count(node_count),
        .node_sel(node_sel), .decrement_degree(decrement_degree), .node_degree(node_degree),
        .adj_req_valid(adj_req_valid), .adj_req_node(adj_req_node), .adj_req_ready(adj_req_ready),
        .adj_rsp_valid(adj_rsp_valid), .adj_rsp_node(adj_rsp_node), .adj_rsp_last(adj_rsp_last),
        .adj_rsp_empty(adj_rsp_empty), .adj_rsp_ready(adj_rsp_ready),
        .order_valid(order_valid), .order_node(order_node),
        .busy(busy), .done(done), .cycle_detected(cycle_detected)
    );

    // Indegree RAM: one-cycle read latency, read-after-decrement.
    int deg [MAXN];
    int load_deg [MAXN];
    bit load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < MAXN; i++) deg[i] = load_deg[i];
        end else if (decrement_degree) begin
            deg[node_sel] = deg[node_sel] - 1;
        end
        node_degree <= NW'(deg[node_sel]);
    end

    // Adjacency source: successor beats queued on request handshake.
    typedef struct {
        int node;
        bit last;
        bit empty;
    } beat_t;

    int    succ [MAXN][4];
    int    succ_n [MAXN];
    beat_t rsp_q [$];

    always @(posedge clk) begin : adj_src
        int    u;
        beat_t b;
        if (rst) begin
            rsp_q.delete();
        end else begin
            if (adj_rsp_valid && adj_rsp_ready && rsp_q.size() > 0) void'(rsp_q.pop_front());
            if (adj_req_valid && adj_req_ready) begin
                u = int'(adj_req_node);
                if (succ_n[u] == 0) begin
                    b.node = 0; b.last = 1'b1; b.empty = 1'b1;
                    rsp_q.push_back(b);
                end else begin
                    for (int k = 0; k < succ_n[u]; k++) begin
                        b.node = succ[u][k]; b.last = (k == succ_n[u] - 1); b.empty = 1'b0;
                        rsp_q.push_back(b);
                    end
                end
            end
        end
        adj_rsp_valid <= (!rst && rsp_q.size() > 0);
        adj_rsp_node  <= (rsp_q.size() > 0) ? NW'(rsp_q[0].node) : '0;
        adj_rsp_last  <= (rsp_q.size() > 0) ? rsp_q[0].last : 1'b0;
        adj_rsp_empty <= (rsp_q.size() > 0) ? rsp_q[0].empty : 1'b0;
    end

    // Monitor: records each emitted node with the decrements it had received.
    int got_q [$];
    int dec_at_emit [$];
    int dec_cnt [MAXN];

    always @(negedge clk) begin
        if (!rst) begin
            if (decrement_degree) dec_cnt[node_sel]++;
            if (order_valid) begin
                got_q.push_back(int'(order_node));
                dec_at_emit.push_back(dec_cnt[order_node]);
            end
        end
    end

    int exp_q [$];

    task automatic clear_graph();
        for (int i = 0; i < MAXN; i++) begin
            load_deg[i] = 0;
            succ_n[i]   = 0;
        end
    endtask

    task automatic add_edge(input int u, input int v);
        succ[u][succ_n[u]] = v;
        succ_n[u]++;
        load_deg[v]++;
    endtask

    task automatic commit_degrees();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic start_sort(input int n);
        node_count = (NW+1)'(n);
        start      = 1'b1;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen, output int cycles, output bit cyc);
        seen = 1'b0; cycles = 0; cyc = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (done) begin
                seen = 1'b1;
                cyc  = cycle_detected;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; node_count = '0; adj_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, order_valid, cycle_detected, adj_req_valid, adj_rsp_ready, decrement_degree,
             node_sel, order_node, adj_req_node} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b ov=%b cyc=%b arv=%b", busy, done,
                     order_valid, cycle_detected, adj_req_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_chain();
        bit seen, cyc; int cycles; int base; int n_exp;
        clear_graph(); add_edge(0, 1); add_edge(1, 2);
        commit_degrees();
        base = got_q.size();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        n_exp = exp_q.size();
        start_sort(3);
        wait_done(200, seen, cycles, cyc);
        checks++;
        if (seen !== 1'b1) begin fails++; $display("[TB] FAIL chain_done: got 0, expected 1"); end
        checks++;
        if (cyc !== 1'b0) begin fails++; $display("[TB] FAIL chain_cycle: got %b, expected 0", cyc); end
        checks++;
        if (got_q.size() - base != n_exp) begin
            fails++; $display("[TB] FAIL chain_len: got %0d, expected %0d", got_q.size() - base, n_exp);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            int e = exp_q.pop_front();
            checks++;
            if (base + k >= got_q.size() || got_q[base + k] !== e) begin
                fails++;
                $display("[TB] FAIL chain_order[%0d]: got %0d, expected %0d", k,
                         (base + k < got_q.size()) ? got_q[base + k] : -1, e);
            end
        end
    endtask

    task automatic test_diamond();
        bit seen, cyc; int cycles; int base; int n_exp; int dbase1, dbase3;
        clear_graph(); add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
        commit_degrees();
        base = got_q.size(); dbase1 = dec_cnt[1]; dbase3 = dec_cnt[3];
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        n_exp = exp_q.size();
        start_sort(4);
        wait_done(300, seen, cycles, cyc);
        checks++;
        if (seen !== 1'b1 || cyc !== 1'b0) begin
            fails++; $display("[TB] FAIL diamond_done: got done=%b cyc=%b, expected 1 0", seen, cyc);
        end
        checks++;
        if (got_q.size() - base != n_exp) begin
            fails++; $display("[TB] FAIL diamond_len: got %0d, expected %0d", got_q.size() - base, n_exp);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            int e = exp_q.pop_front();
            checks++;
            if (base + k >= got_q.size() || got_q[base + k] !== e) begin
                fails++;
                $display("[TB] FAIL diamond_order[%0d]: got %0d, expected %0d", k,
                         (base + k < got_q.size()) ? got_q[base + k] : -1, e);
            end
        end
        if (got_q.size() - base == n_exp) begin
            checks++;
            if (dec_at_emit[base + 1] - dbase1 != 1) begin
                fails++; $display("[TB] FAIL diamond_dec1: got %0d, expected 1", dec_at_emit[base + 1] - dbase1);
            end
            checks++;
            if (dec_at_emit[base + 3] - dbase3 != 2) begin
                fails++; $display("[TB] FAIL diamond_dec3: got %0d, expected 2", dec_at_emit[base + 3] - dbase3);
            end
        end
    endtask

    task automatic test_cycle();
        bit seen, cyc; int cycles; int base;
        clear_graph(); add_edge(1, 2); add_edge(2, 1);
        commit_degrees();
        base = got_q.size();
        exp_q.push_back(0);
        start_sort(3);
        wait_done(200, seen, cycles, cyc);
        checks++;
        if (seen !== 1'b1 || cyc !== 1'b1) begin
            fails++; $display("[TB] FAIL cycle_flag: got done=%b cyc=%b, expected 1 1", seen, cyc);
        end
        checks++;
        if (got_q.size() - base != 1) begin
            fails++; $display("[TB] FAIL cycle_len: got %0d, expected 1", got_q.size() - base);
        end
        begin
            int e = exp_q.pop_front();
            checks++;
            if (got_q.size() <= base || got_q[base] !== e) begin
                fails++; $display("[TB] FAIL cycle_order: got %0d, expected %0d",
                                  (got_q.size() > base) ? got_q[base] : -1, e);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (cycle_detected !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("[TB] FAIL cycle_held: got cyc=%b busy=%b, expected 1 0", cycle_detected, busy);
        end
    endtask

    task automatic test_empty_graph();
        bit seen, cyc; int cycles; int base;
        base = got_q.size();
        start_sort(0);
        wait_done(10, seen, cycles, cyc);
        checks++;
        if (seen !== 1'b1 || cycles > 2) begin
            fails++; $display("[TB] FAIL n0_done: got done=%b after %0d cycles, expected 1 within 2", seen, cycles);
        end
        checks++;
        if (cyc !== 1'b0) begin fails++; $display("[TB] FAIL n0_cycle: got %b, expected 0", cyc); end
        checks++;
        if (got_q.size() != base) begin
            fails++; $display("[TB] FAIL n0_order: got %0d pulses, expected 0", got_q.size() - base);
        end
    endtask

    task automatic test_req_stall();
        bit seen, cyc; int cycles; int base; int n_exp; bit found; logic [NW-1:0] held;
        clear_graph(); add_edge(0, 1); add_edge(1, 2);
        commit_degrees();
        base = got_q.size();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        n_exp = exp_q.size();
        adj_req_ready = 1'b0;
        start_sort(3);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            start = 1'b0;
            found = adj_req_valid;
        end
        checks++;
        if (!found) begin fails++; $display("[TB] FAIL stall_req_seen: got 0, expected 1"); end
        held = adj_req_node;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (adj_req_valid !== 1'b1 || adj_req_node !== held || decrement_degree !== 1'b0) begin
                fails++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b node=%0d dec=%b, expected 1 %0d 0", i,
                         adj_req_valid, adj_req_node, decrement_degree, held);
            end
        end
        adj_req_ready = 1'b1;
        wait_done(200, seen, cycles, cyc);
        checks++;
        if (seen !== 1'b1 || cyc !== 1'b0 || got_q.size() - base != n_exp) begin
            fails++; $display("[TB] FAIL stall_done: got done=%b cyc=%b len=%0d, expected 1 0 %0d",
                              seen, cyc, got_q.size() - base, n_exp);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            int e = exp_q.pop_front();
            checks++;
            if (base + k >= got_q.size() || got_q[base + k] !== e) begin
                fails++;
                $display("[TB] FAIL stall_order[%0d]: got %0d, expected %0d", k,
                         (base + k < got_q.size()) ? got_q[base + k] : -1, e);
            end
        end
    endtask

    task automatic test_reset_mid_sort();
        bit found;
        clear_graph(); add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
        commit_degrees();
        start_sort(4);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            start = 1'b0;
            found = decrement_degree;
        end
        checks++;
        if (!found) begin fails++; $display("[TB] FAIL rstmid_decr_seen: got 0, expected 1"); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, order_valid, cycle_detected, adj_req_valid, adj_rsp_ready, decrement_degree,
             node_sel, order_node, adj_req_node} !== '0) begin
            fails++; $display("[TB] FAIL rstmid_during: got busy=%b rsp_ready=%b, expected all zero",
                              busy, adj_rsp_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, order_valid, cycle_detected, adj_req_valid, adj_rsp_ready, decrement_degree,
             node_sel, order_node, adj_req_node} !== '0) begin
            fails++; $display("[TB] FAIL rstmid_after: got busy=%b rsp_ready=%b, expected all zero",
                              busy, adj_rsp_ready);
        end
        @(negedge clk);
        test_diamond();
    endtask

    initial begin
        $display("[TB] topo_sort_scheduler bench starting");
        test_reset();
        test_chain();
        test_diamond();
        test_cycle();
        test_empty_graph();
        test_req_stall();
        test_reset_mid_sort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/topo_sort_scheduler.md
TOPO_SORT_SCHEDULER -- requirements
Module: topo_sort_scheduler

Interface
REQ-001 The block SHALL have parameter MAX_NODES, default 1024, meaning the node-ID space and the ready-FIFO depth.
REQ-002 The block SHALL have parameter NODE_WIDTH, default $clog2(MAX_NODES), meaning the width of node IDs and degree counts.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a sort; it is ignored unless the block is IDLE.
REQ-006 The block SHALL have port node_count, input, NODE_WIDTH+1 bits: the number of nodes N, with IDs 0..N-1; it is sampled on start.
REQ-007 The block SHALL have port node_sel, output, NODE_WIDTH bits: the node address to the indegree list.
REQ-008 The block SHALL have port decrement_degree, output, 1 bit: a request to the indegree list to decrement the degree of node_sel.
REQ-009 The block SHALL have port node_degree, input, NODE_WIDTH bits: the degree of the node_sel presented in the previous cycle, taken after any decrement.
REQ-010 The block SHALL have ports adj_req_valid (output, 1 bit) and adj_req_node (output, NODE_WIDTH bits): a successor-list fetch request for one node.
REQ-011 The block SHALL have port adj_req_ready, input, 1 bit: acceptance of the fetch request.
REQ-012 The block SHALL have ports adj_rsp_valid (input, 1 bit), adj_rsp_node (input, NODE_WIDTH bits), adj_rsp_last (input, 1 bit) and adj_rsp_empty (input, 1 bit): the successor stream; empty means the node has no successors and the beat's node field is ignored.
REQ-013 The block SHALL have port adj_rsp_ready, output, 1 bit: the scheduler accepts the current successor beat.
REQ-014 The block SHALL have ports order_valid (output, 1 bit) and order_node (output, NODE_WIDTH bits): the topological order, one node per valid pulse.
REQ-015 The block SHALL have ports busy (output, 1 bit), done (output, 1-cycle pulse) and cycle_detected (output, 1 bit, held until next start).

Function
REQ-016 FSM states SHALL be IDLE, SCAN, POP, ADJ_REQ, ADJ_RSP, DECR_WAIT and FINISH.
REQ-017 IDLE + start: the block SHALL capture N, clear the scan index, emitted count and FIFO, clear cycle_detected, and go to SCAN; start with N=0 SHALL go directly to FINISH.
REQ-018 SCAN: the block SHALL drive node_sel = i for i = 0..N-1 on consecutive cycles with decrement_degree=0; the degree returned one cycle later for node i-1 SHALL, when 0, push i-1 into the ready FIFO; SCAN SHALL end one cycle after i = N-1 is issued (pipeline drain), then go to POP.
REQ-019 POP with FIFO non-empty: the block SHALL pop the head, pulse order_valid with order_node = head, increment the emitted count, and go to ADJ_REQ.
REQ-020 POP with FIFO empty: the block SHALL go to FINISH.
REQ-021 ADJ_REQ: the block SHALL assert adj_req_valid with adj_req_node = popped node and hold both stable until adj_req_ready; on handshake it SHALL go to ADJ_RSP.
REQ-022 ADJ_RSP: adj_rsp_ready SHALL be 1.
REQ-023 ADJ_RSP: on a beat with empty=1, the block SHALL go to POP.
REQ-024 ADJ_RSP: on a beat with empty=0, the block SHALL drive node_sel = adj_rsp_node with decrement_degree=1 for exactly one cycle, latch the node and last flag, and go to DECR_WAIT.
REQ-025 DECR_WAIT: adj_rsp_ready SHALL be 0; the block SHALL sample node_degree; value 0 SHALL push the latched node into the FIFO.
REQ-026 DECR_WAIT: if the latched last flag was 1 the block SHALL then go to POP, otherwise it SHALL go to ADJ_RSP. This gives at most one decrement every 2 cycles, so no two consecutive decrements can target the RAM.
REQ-027 FIFO push in DECR_WAIT and pop in POP SHALL never coincide; a push when full SHALL NOT occur for a legal graph, and if it does occur it SHALL be dropped and set cycle_detected.
REQ-028 The emitted count SHALL be NODE_WIDTH+1 bits and SHALL NOT wrap for N <= MAX_NODES.
REQ-029 FINISH: the block SHALL pulse done for one cycle, set cycle_detected = (emitted count != N), and go to IDLE.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 start while busy SHALL be ignored.
REQ-032 decrement_degree SHALL be 0 in every state except the ADJ_RSP accept cycle.

Reset
REQ-033 When rst=1, the FSM SHALL go to IDLE, the FIFO SHALL be emptied and all counters SHALL be cleared, regardless of the current state.
REQ-034 During reset, outputs SHALL be: busy=0, done=0, order_valid=0, cycle_detected=0, adj_req_valid=0, adj_rsp_ready=0, decrement_degree=0, node_sel=0, order_node=0, adj_req_node=0.
REQ-035 An outstanding adjacency transaction SHALL be abandoned on reset; the external adjacency source is reset together with this block.
REQ-036 Indegree-list contents SHALL NOT be cleared by this block.

Verification
REQ-037 Chain 0->1->2 (N=3, degrees 0,1,1): start -> order 0,1,2, done, cycle_detected=0.
REQ-038 Diamond 0->1, 0->2, 1->3, 2->3: order 0,1,2,3; node 3 is emitted only after its second decrement reaches 0.
REQ-039 Cycle 1->2->1 plus isolated node 0: order 0 only, done, cycle_detected=1.
REQ-040 N=0: start -> done within 2 cycles, no order_valid, cycle_detected=0.
REQ-041 adj_req_ready held low for 5 cycles: adj_req_valid and adj_req_node stay stable, no decrement issued, and the final order is unchanged.
REQ-042 rst asserted in DECR_WAIT mid-sort: next cycle busy=0 and all outputs are at reset values; a new start produces a correct sort after the indegree list is reloaded.
